// File: rtl/turn_sequencer_pkg.sv
// turn_pkg: shared state encoding and player/colour helpers for the turn sequencer.
package turn_pkg;
  typedef enum logic [1:0] {IDLE, WAIT_MOVE, WAIT_CHECK, GAME_OVER} state_e;
  localparam int COLOR_NONE = 0;
  function automatic int player_to_color(input int idx);
    return idx + 1;
  endfunction
  function automatic int next_player(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction
endpackage

// File: rtl/turn_sequencer_move_timer.sv
// move_timer: counts cycles while enabled and pulses expire on the last allowed cycle.
module move_timer #(
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);
  localparam int TW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] cnt_q, cnt_d;
  // A zero timeout never expires, so the counter is left free-running and unobserved.
  assign expire = (TIMEOUT_CYCLES > 0) && enable && (cnt_q == TW'(TIMEOUT_CYCLES - 1));
  assign cnt_d = (clear || expire) ? '0 : enable ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/turn_sequencer.sv
// turn_sequencer: N-player turn tracking with move/verdict handshake, win/draw freeze and move timeout.
module turn_sequencer
  import turn_pkg::*;
#(
  parameter int NUM_PLAYERS    = 2,
  parameter int FIRST_PLAYER   = 0,
  parameter int COLOR_W        = 2,
  parameter int COUNT_W        = 6,
  parameter int TIMEOUT_CYCLES = 0,
  localparam int PW = NUM_PLAYERS > 1 ? $clog2(NUM_PLAYERS) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               move_valid,
  output logic               move_ready,
  input  logic               check_done,
  input  logic               check_win,
  input  logic               check_draw,
  output logic [PW-1:0]      turn_player,
  output logic [COLOR_W-1:0] turn_color,
  output logic [COUNT_W-1:0] turn_count,
  output logic               timeout_skip,
  output logic               game_over,
  output logic               winner_valid,
  output logic [PW-1:0]      winner
);
  state_e             state_q;
  logic [PW-1:0]      player_q, winner_q, player_adv;
  logic [COUNT_W-1:0] count_q, count_inc;
  logic               winner_valid_q, skip_q, in_move, restart, expire;
  assign in_move    = state_q == WAIT_MOVE;
  assign restart    = start && (state_q == IDLE || state_q == GAME_OVER);
  assign player_adv = PW'(next_player(int'(player_q), NUM_PLAYERS));
  assign count_inc  = (&count_q) ? count_q : count_q + 1'b1;
  move_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (restart || (in_move && move_valid)),
    .enable (in_move),
    .expire (expire)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      player_q       <= PW'(FIRST_PLAYER);
      count_q        <= '0;
      winner_q       <= '0;
      winner_valid_q <= 1'b0;
      skip_q         <= 1'b0;
    end else begin
      skip_q <= 1'b0;
      case (state_q)
        IDLE, GAME_OVER:
          if (start) begin
            state_q        <= WAIT_MOVE;
            player_q       <= PW'(FIRST_PLAYER);
            count_q        <= '0;
            winner_q       <= '0;
            winner_valid_q <= 1'b0;
          end
        WAIT_MOVE:
          if (move_valid) state_q <= WAIT_CHECK;
          else if (expire) begin
            player_q <= player_adv;
            skip_q   <= 1'b1;
          end
        WAIT_CHECK:
          if (check_done) begin
            if (check_win) begin
              state_q        <= GAME_OVER;
              winner_q       <= player_q;
              winner_valid_q <= 1'b1;
            end else if (check_draw) state_q <= GAME_OVER;
            else begin
              state_q  <= WAIT_MOVE;
              player_q <= player_adv;
              count_q  <= count_inc;
            end
          end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign move_ready   = in_move;
  assign turn_player  = player_q;
  assign turn_color   = (state_q == WAIT_MOVE || state_q == WAIT_CHECK) ?
                        COLOR_W'(player_to_color(int'(player_q))) : COLOR_W'(COLOR_NONE);
  assign turn_count   = count_q;
  assign timeout_skip = skip_q;
  assign game_over    = state_q == GAME_OVER;
  assign winner_valid = winner_valid_q;
  assign winner       = winner_q;
endmodule

// File: doc/turn_sequencer.md
Name: turn_sequencer

Overview:
- Parametrised successor to the 2-player turn toggle. Tracks whose turn it is for NUM_PLAYERS players and emits each player's board colour code.
- Handshakes each move with the input front end, then waits for the board/win-check logic to return a verdict before advancing.
- Freezes on win or draw. An optional move timeout forfeits a stalled player's turn.
- Sits between the move-input controller and the board RAM / win checker.

Parameters:
- NUM_PLAYERS, 2, number of players (2..4); turn order wraps from NUM_PLAYERS-1 to 0.
- FIRST_PLAYER, 0, player index that moves first after start.
- COLOR_W, 2, width of colour code; colour = player index + 1, 0 = empty/none.
- COUNT_W, 6, width of completed-move counter (42 cells fit).
- TIMEOUT_CYCLES, 0, cycles allowed per move; 0 disables timeout.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin new game; honoured only in IDLE or GAME_OVER.
- move_valid  in  1  front end presents a move for turn_player.
- move_ready  out  1  high while in WAIT_MOVE.
- check_done  in  1  board/win checker verdict valid (single-cycle pulse).
- check_win  in  1  qualified by check_done: last move won.
- check_draw  in  1  qualified by check_done: board full, no win.
- turn_player  out  $clog2(NUM_PLAYERS) (min 1)  current player index.
- turn_color  out  COLOR_W  turn_player+1 in WAIT_MOVE/WAIT_CHECK, else 0.
- turn_count  out  COUNT_W  completed (non-winning, non-forfeited) moves this game.
- timeout_skip  out  1  one-cycle pulse when a turn is forfeited.
- game_over  out  1  high in GAME_OVER.
- winner_valid  out  1  high in GAME_OVER when ended by win.
- winner  out  $clog2(NUM_PLAYERS)  winning player index; valid with winner_valid.

Behaviour:
- Reset (async, any state): state IDLE; turn_player=FIRST_PLAYER; turn_count=0; timer=0; all flags/pulses 0; winner=0.
- States: IDLE, WAIT_MOVE, WAIT_CHECK, GAME_OVER.
- IDLE: start -> WAIT_MOVE next cycle; turn_player=FIRST_PLAYER, turn_count=0, timer=0.
- WAIT_MOVE: move_ready=1. move_valid&move_ready -> WAIT_CHECK; timer cleared. Turn_player is unchanged until the verdict.
- Timeout: applies only if TIMEOUT_CYCLES>0. The timer counts each cycle in WAIT_MOVE. On the cycle timer==TIMEOUT_CYCLES-1 with no move:
  - advance turn_player (wrap) and clear timer;
  - pulse timeout_skip for that cycle; stay in WAIT_MOVE; turn_count unchanged.
- Move and timeout in the same cycle: the move wins, with no skip pulse.
- WAIT_CHECK: move_ready=0, timer frozen. On check_done:
  - check_win -> GAME_OVER, winner=turn_player, winner_valid=1;
  - else check_draw -> GAME_OVER, winner_valid=0;
  - else turn_player advances (wrap), turn_count+=1 (saturating at all-ones) -> WAIT_MOVE.
- Win and draw asserted together: win has priority.
- check_done outside WAIT_CHECK: ignored.
- GAME_OVER: all outputs hold, turn_color=0. start -> WAIT_MOVE with full game reinitialisation; winner_valid clears.
- start in WAIT_MOVE/WAIT_CHECK: ignored. The only abort mid-game is reset.
- Latency: every state transition and turn_player update is visible 1 cycle after the qualifying input edge. Outputs are registered or decoded from state only, with no input-to-output combinational path.
- Reset asserted mid-move or mid-check returns to IDLE immediately. Any pending check_done is then dropped.

Decomposition:
- Package turn_pkg:
  - state enum (IDLE, WAIT_MOVE, WAIT_CHECK, GAME_OVER);
  - COLOR_NONE=0;
  - function player_to_color(idx)=idx+1;
  - function next_player(idx, n) with wrap.
- Sub-module move_timer: clear/enable inputs, expire pulse out; tied off when TIMEOUT_CYCLES=0.

Test Plan:
- Reset then start, 2 players: turn_player=0, turn_color=01, move_ready=1. One move plus check_done with no win/draw -> turn_player=1, turn_color=10, turn_count=1.
- NUM_PLAYERS=3: three non-winning moves -> turn_player sequence 0,1,2,0 and turn_count=3.
- check_done with check_win=1 and check_draw=1 on player 1's move -> game_over=1, winner_valid=1, winner=1, turn_color=0. A later move_valid is ignored.
- TIMEOUT_CYCLES=8, no move -> timeout_skip pulses on the 8th WAIT_MOVE cycle, turn_player 0->1. Move_valid exactly on that cycle -> no skip, state WAIT_CHECK.
- Assert reset while in WAIT_CHECK -> IDLE immediately, all outputs at reset values. A check_done after release has no effect.
- Draw verdict -> game_over=1, winner_valid=0. Start -> WAIT_MOVE, turn_player=FIRST_PLAYER, turn_count=0.
